// File: rtl/md_unit_pkg.sv
// Shared types for the multiply/divide unit: opcodes, FSM states and result payload.
package md_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_OP_W  = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [MD_WIDTH-1:0] hi;
    logic [MD_WIDTH-1:0] lo;
    logic                div0;
  } md_res_t;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage <-> multiply/divide unit handshake and HI/LO read port.
interface md_unit_if;
  import md_unit_pkg::*;

  logic                start;
  md_op_e              op;
  logic                we;
  logic                flush;
  logic [MD_WIDTH-1:0] a;
  logic [MD_WIDTH-1:0] b;
  logic                rd_hi;
  logic                busy;
  logic [MD_WIDTH-1:0] rdata;

  modport master (
    output start, op, we, flush, a, b, rd_hi,
    input  busy, rdata
  );

  modport slave (
    input  start, op, we, flush, a, b, rd_hi,
    output busy, rdata
  );

endinterface

// File: rtl/md_unit_arith.sv
// Combinational arithmetic core: (op, a, b) -> {hi, lo, div0}.
module md_unit_arith
  import md_unit_pkg::*;
(
  input  md_op_e              i_op,
  input  logic [MD_WIDTH-1:0] i_a,
  input  logic [MD_WIDTH-1:0] i_b,
  output md_res_t             o_res
);

  localparam int unsigned W = MD_WIDTH;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [2*W-1:0]  w_a_ext;
  logic [2*W-1:0]  w_b_ext;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_num;
  logic [W-1:0]    w_den;
  logic [W-1:0]    w_den_safe;
  logic [W-1:0]    w_quo_mag;
  logic [W-1:0]    w_rem_mag;
  logic [W-1:0]    w_quo;
  logic [W-1:0]    w_rem;
  logic            w_div0;

  assign w_signed = md_is_signed(i_op);
  assign w_a_neg  = w_signed & i_a[W-1];
  assign w_b_neg  = w_signed & i_b[W-1];

  // Extending to 2W before multiplying keeps the full product; the low 2W bits
  // of a sign-extended product equal the two's-complement signed product.
  assign w_a_ext = w_signed ? {{W{i_a[W-1]}}, i_a} : {{W{1'b0}}, i_a};
  assign w_b_ext = w_signed ? {{W{i_b[W-1]}}, i_b} : {{W{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide via magnitudes gives truncation toward zero and makes
  // MIN/-1 wrap to MIN without relying on signed-overflow behaviour.
  assign w_num      = w_a_neg ? (W'(0) - i_a) : i_a;
  assign w_den      = w_b_neg ? (W'(0) - i_b) : i_b;
  assign w_div0     = (i_b == '0);
  assign w_den_safe = w_div0 ? W'(1) : w_den;
  assign w_quo_mag  = w_num / w_den_safe;
  assign w_rem_mag  = w_num % w_den_safe;
  assign w_quo      = (w_a_neg ^ w_b_neg) ? (W'(0) - w_quo_mag) : w_quo_mag;
  assign w_rem      = w_a_neg ? (W'(0) - w_rem_mag) : w_rem_mag;

  always_comb begin
    o_res = '0;
    unique case (i_op)
      MD_MULT, MD_MULTU: begin
        o_res.hi = w_prod[2*W-1:W];
        o_res.lo = w_prod[W-1:0];
      end
      MD_DIV, MD_DIVU: begin
        o_res.hi   = w_rem;
        o_res.lo   = w_quo;
        o_res.div0 = w_div0;
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: latches an operation, counts down a fixed latency,
// then commits to HI/LO; drives the busy flag used by stall control.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  md_res_t             r_pend;
  md_res_t             w_arith;
  logic [MD_WIDTH-1:0] r_hi;
  logic [MD_WIDTH-1:0] r_lo;
  logic [MD_WIDTH-1:0] w_hi_d;
  logic [MD_WIDTH-1:0] w_lo_d;
  logic                w_hi_we;
  logic                w_lo_we;
  logic                w_busy_q;
  logic                w_accept;
  logic                w_mt_wr;
  logic                w_commit;

  md_unit_arith u_arith (
    .i_op  (bus.op),
    .i_a   (bus.a),
    .i_b   (bus.b),
    .o_res (w_arith)
  );

  assign w_busy_q  = (r_state == MD_RUN);
  assign bus.busy  = w_busy_q | (bus.start & ~bus.flush);
  assign bus.rdata = bus.rd_hi ? r_hi : r_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, countdown and HI/LO write decode; start wins over we in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_mt_wr     = 1'b0;
    w_commit    = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_d      = r_pend.hi;
    w_lo_d      = r_pend.lo;
    unique case (r_state)
      MD_IDLE: begin
        if (bus.start && !bus.flush) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = md_is_div(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_nxt = MD_RUN;
        end else if (bus.we && !bus.flush) begin
          w_mt_wr = 1'b1;
          w_hi_d  = bus.a;
          w_lo_d  = bus.a;
          w_hi_we = (bus.op == MD_MTHI);
          w_lo_we = (bus.op == MD_MTLO);
        end
      end
      MD_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
          w_state_nxt = MD_IDLE;
          w_hi_we     = ~r_pend.div0;
          w_lo_we     = ~r_pend.div0;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_accept) begin
        r_pend <= w_arith;
      end
      if (w_hi_we) begin
        r_hi <= w_hi_d;
      end
      if (w_lo_we) begin
        r_lo <= w_lo_d;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver queues expected busy/rdata per observed
// cycle, a negedge monitor pops and compares.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  md_unit_if bus();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          cb;
    bit          eb;
    bit          cr;
    logic [31:0] er;
  } exp_t;

  exp_t sb_q[$];
  bit   obs = 1'b0;
  bit   done = 1'b0;
  bit   end_chk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    obs = 1'b0;
  endtask

  task automatic expect_c(input string nm, input bit cb, input bit eb,
                          input bit cr, input bit rh, input logic [31:0] er);
    exp_t e;
    e.name = nm;
    e.cb   = cb;
    e.eb   = eb;
    e.cr   = cr;
    e.er   = er;
    sb_q.push_back(e);
    bus.rd_hi = rh;
    obs = 1'b1;
  endtask

  task automatic run_op(input string nm, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    expect_c({nm, "_busy_issue"}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      expect_c({nm, "_busy_run"}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    expect_c({nm, "_hi"}, 1'b1, 1'b0, 1'b1, 1'b1, ehi);
    tick();
    expect_c({nm, "_lo"}, 1'b1, 1'b0, 1'b1, 1'b0, elo);
    tick();
  endtask

  task automatic mt_write(input string nm, input md_op_e op, input logic [31:0] val,
                          input bit fl);
    bus.we    = 1'b1;
    bus.op    = op;
    bus.a     = val;
    bus.flush = fl;
    expect_c({nm, "_busy"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    bus.we    = 1'b0;
    bus.flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (obs) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: observation with no expectation queued");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cb) begin
          checks++;
          if (bus.busy !== e.eb) begin
            errors++;
            $display("FAIL %s: busy=%0b expected %0b", e.name, bus.busy, e.eb);
          end
        end
        if (e.cr) begin
          checks++;
          if (bus.rdata !== e.er) begin
            errors++;
            $display("FAIL %s: rdata=0x%08h expected 0x%08h", e.name, bus.rdata, e.er);
          end
        end
      end
    end
    if (done && !end_chk) begin
      end_chk = 1'b1;
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.we    = 1'b0;
    bus.flush = 1'b0;
    bus.op    = MD_MULT;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.rd_hi = 1'b0;
    reset     = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    expect_c("rst_lo", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    expect_c("rst_hi", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();

    run_op("t1_mult",     MD_MULT,  32'hFFFFFFFD, 32'h00000007, 5,  32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("t2_multu",    MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE);
    run_op("mult_minmin", MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000);
    run_op("t3_div",      MD_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb",    MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divu",        MD_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E);

    mt_write("t4_mthi", MD_MTHI, 32'h11, 1'b0);
    mt_write("t4_mtlo", MD_MTLO, 32'h22, 1'b0);
    run_op("t4_div0", MD_DIVU, 32'd100, 32'd0, 10, 32'h00000011, 32'h00000022);

    // Flushed start and flushed MTLO must leave HI/LO and busy untouched.
    bus.start = 1'b1;
    bus.op    = MD_MULT;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.flush = 1'b1;
    expect_c("t5_flush_busy", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expect_c("t5_after_flush", 1'b1, 1'b0, 1'b1, i[0], i[0] ? 32'h11 : 32'h22);
      tick();
    end
    mt_write("t5_mtlo_flush", MD_MTLO, 32'h99, 1'b1);
    expect_c("t5_lo_kept", 1'b1, 1'b0, 1'b1, 1'b0, 32'h22);
    tick();

    // Reset during a DIV at its cycle 3.
    bus.start = 1'b1;
    bus.op    = MD_DIV;
    bus.a     = 32'hFFFFFFF9;
    bus.b     = 32'd2;
    expect_c("t6_busy_issue", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      expect_c("t6_busy_run", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    reset = 1'b1;
    expect_c("t6_busy_at_rst", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      expect_c("t6_after_rst", 1'b1, 1'b0, 1'b1, i[0], 32'h0);
      tick();
    end
    mt_write("t6_mthi", MD_MTHI, 32'h1234, 1'b0);
    expect_c("t6_hi_new", 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234);
    tick();
    expect_c("t6_lo_zero", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();

    done = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
